// File: rtl/register_file_mp_pkg.sv
// Shared constants and clear-engine state encodings for register_file_mp.
package register_file_mp_pkg;

  localparam int DEF_DATA_WIDTH = 32'd32;
  localparam int DEF_ADDR_WIDTH = 32'd5;
  localparam int DEF_DEPTH      = 32'd1 << DEF_ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_CLEARING = 1'b1;

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port of register_file_mp: address mux, write-first bypass
// compare and output register that holds when no read is accepted.
module reg_file_read_port
  import register_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           rd_en,
  input  logic                                           byp_en,
  input  logic [ADDR_WIDTH-1:0]                          addr_rd,
  input  logic [ADDR_WIDTH-1:0]                          addr_wr,
  input  logic [DATA_WIDTH-1:0]                          data_wr,
  input  logic [(32'd1 << ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
  output logic [DATA_WIDTH-1:0]                          data_rd
);

  logic [DATA_WIDTH-1:0] next_data_s;
  logic [DATA_WIDTH-1:0] data_rd_r;

  // Forward the in-flight write when it targets this port's address.
  always_comb begin
    next_data_s = regs[addr_rd];
    if (byp_en && (addr_rd == addr_wr)) begin
      next_data_s = data_wr;
    end else begin
      next_data_s = regs[addr_rd];
    end
  end

  // Output register, updated only on an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_rd_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      data_rd_r <= next_data_s;
    end else begin
      data_rd_r <= data_rd_r;
    end
  end

  assign data_rd = data_rd_r;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file with registered reads, write-first
// bypass and a sequential bulk-clear engine. Optional: REG_FILE_ZERO_REG_EN
// hardwires register 0 to zero.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 32'd2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         READ,
  input  logic                         WRITE,
  input  logic [ADDR_WIDTH-1:0]        ADDR_W,
  input  logic [DATA_WIDTH-1:0]        DATA_W,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ADDR_R,
  output logic [NUM_RD*DATA_WIDTH-1:0] DATA_R,
  output logic                         R_VALID,
  input  logic                         CLR,
  output logic                         BUSY
);

  localparam int DEPTH = 32'd1 << ADDR_WIDTH;
`ifdef REG_FILE_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);

  logic [0:0]                            state_r;
  logic [ADDR_WIDTH-1:0]                 clr_cnt_r;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]      mem_r;
  logic                                  r_valid_r;
  logic                                  idle_s;
  logic                                  rd_acc_s;
  logic                                  wr_acc_s;

  // Host traffic is accepted only while idle; writes to a hardwired zero register are dropped.
  always_comb begin
    idle_s   = (state_r == ST_IDLE);
    rd_acc_s = idle_s & READ;
    if (ZERO_REG && (ADDR_W == ADDR_ZERO)) begin
      wr_acc_s = 1'b0;
    end else begin
      wr_acc_s = idle_s & WRITE;
    end
  end

  // Clear engine: walk every address once, then fall back to idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      clr_cnt_r <= ADDR_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          clr_cnt_r <= ADDR_ZERO;
          if (CLR) begin
            state_r <= ST_CLEARING;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLEARING: begin
          clr_cnt_r <= clr_cnt_r + ADDR_ONE;
          if (clr_cnt_r == ADDR_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_CLEARING;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          clr_cnt_r <= ADDR_ZERO;
        end
      endcase
    end
  end

  // Storage: clear engine owns the write path while active.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_r <= {(DEPTH*DATA_WIDTH){1'b0}};
    end else if (state_r == ST_CLEARING) begin
      mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr_acc_s) begin
      mem_r[ADDR_W] <= DATA_W;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Read-valid flag follows an accepted read by one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_valid_r <= 1'b0;
    end else begin
      r_valid_r <= rd_acc_s;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port (
      .clk     (CLK),
      .rst_n   (RST),
      .rd_en   (rd_acc_s),
      .byp_en  (wr_acc_s),
      .addr_rd (ADDR_R[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .addr_wr (ADDR_W),
      .data_wr (DATA_W),
      .regs    (mem_r),
      .data_rd (DATA_R[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign R_VALID = r_valid_r;
  assign BUSY    = (state_r == ST_CLEARING);

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (defaults, two read ports): directed
// table, bulk-clear and reset sequences, then randomized traffic against a model.
module tb_register_file_mp;
  import register_file_mp_pkg::*;

  localparam int DW    = DEF_DATA_WIDTH;
  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int NR    = 2;
  localparam int DEPTH = DEF_DEPTH;
`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              READ = 1'b0;
  logic              WRITE = 1'b0;
  logic              CLR = 1'b0;
  logic [AW-1:0]     ADDR_W = '0;
  logic [DW-1:0]     DATA_W = '0;
  logic [NR*AW-1:0]  ADDR_R = '0;
  logic [NR*DW-1:0]  DATA_R;
  logic              R_VALID;
  logic              BUSY;

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
    .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .ADDR_R(ADDR_R), .DATA_R(DATA_R), .R_VALID(R_VALID),
    .CLR(CLR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // reference model
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_d [NR];
  logic        exp_v;
  int          clear_left;
  int          clear_idx;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ev;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".d0"}, DATA_R[31:0], exp_d[0]);
    chk({tag, ".d1"}, DATA_R[63:32], exp_d[1]);
    chk({tag, ".valid"}, {31'd0, R_VALID}, {31'd0, exp_v});
    chk({tag, ".busy"}, {31'd0, BUSY}, {31'd0, clear_left > 0});
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
    exp_d[0] = 32'd0;
    exp_d[1] = 32'd0;
    exp_v = 1'b0;
    clear_left = 0;
    clear_idx = 0;
  endtask

  task automatic step(input logic rd, input logic wr, input logic [4:0] aw, input logic [31:0] dw,
                      input logic [4:0] a0, input logic [4:0] a1, input logic clr, input string tag);
    logic byp;
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDR_W = aw; DATA_W = dw; ADDR_R = {a1, a0}; CLR = clr;
    @(posedge CLK);
    if (clear_left > 0) begin
      mem_m[clear_idx] = 32'd0;
      clear_idx++;
      clear_left--;
      exp_v = 1'b0;
    end else begin
      byp = wr && !(ZERO_EN && aw == 5'd0);
      if (rd) begin
        exp_d[0] = (byp && a0 == aw) ? dw : mem_m[a0];
        exp_d[1] = (byp && a1 == aw) ? dw : mem_m[a1];
      end
      exp_v = rd;
      if (byp) mem_m[aw] = dw;
      if (clr) begin
        clear_left = DEPTH;
        clear_idx = 0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge CLK);
    #2;
    RST = 1'b0; READ = 1'b0; WRITE = 1'b0; CLR = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] z0;
    int busy_cnt;
    z0 = ZERO_EN ? 32'h0 : 32'hFFFF_FFFF;
    tbl[0] = '{1'b1, 1'b0, 5'd0, 32'h0,         5'd3, 5'd7, 32'h0,         32'h0,         1'b1};
    tbl[1] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF,  5'd0, 5'd0, 32'h0,         32'h0,         1'b0};
    tbl[2] = '{1'b1, 1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 32'hDEADBEEF,  32'h0,         1'b1};
    tbl[3] = '{1'b0, 1'b1, 5'd2, 32'hA5A5A5A5,  5'd0, 5'd0, 32'hDEADBEEF,  32'h0,         1'b0};
    tbl[4] = '{1'b1, 1'b1, 5'd9, 32'h12345678,  5'd9, 5'd2, 32'h12345678,  32'hA5A5A5A5,  1'b1};
    tbl[5] = '{1'b1, 1'b0, 5'd0, 32'h0,         5'd9, 5'd5, 32'h12345678,  32'hDEADBEEF,  1'b1};
    tbl[6] = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF,  5'd0, 5'd0, z0,            z0,            1'b1};
    tbl[7] = '{1'b1, 1'b0, 5'd0, 32'h0,         5'd0, 5'd9, z0,            32'h12345678,  1'b1};
    tbl[8] = '{1'b0, 1'b0, 5'd0, 32'h0,         5'd1, 5'd1, z0,            32'h12345678,  1'b0};

    apply_reset("reset");

    // directed table
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].aw, tbl[i].dw, tbl[i].a0, tbl[i].a1, 1'b0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.d0_table", i), DATA_R[31:0], tbl[i].e0);
      chk($sformatf("tbl%0d.d1_table", i), DATA_R[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d.valid_table", i), {31'd0, R_VALID}, {31'd0, tbl[i].ev});
    end

    // bulk clear: fill, clear with concurrent read/write, count busy cycles
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 5'(i), 32'h1000_0000 + 32'(i) * 32'h0101, 5'd0, 5'd0, 1'b0, "fill");
    step(1'b1, 1'b1, 5'd4, 32'h7777_0004, 5'd4, 5'd1, 1'b1, "clr_start");
    chk("clr_start.bypass", DATA_R[31:0], 32'h7777_0004);
    busy_cnt = BUSY ? 1 : 0;
    for (int i = 0; i < DEPTH; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
           5'($urandom), 5'($urandom), $urandom_range(0, 1) == 1, "clearing");
      if (BUSY) busy_cnt++;
    end
    chk("clr.busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    for (int i = 0; i < DEPTH / 2; i++) begin
      step(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i + DEPTH / 2), 1'b0, "after_clr");
      chk("after_clr.zero0", DATA_R[31:0], 32'd0);
      chk("after_clr.zero1", DATA_R[63:32], 32'd0);
    end

    // reset in the middle of a clear
    step(1'b0, 1'b1, 5'd3, 32'h5555_AAAA, 5'd0, 5'd0, 1'b0, "pre_clr");
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, "clr2_start");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, "clr2_run");
    apply_reset("mid_clr_reset");
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd31, 1'b0, "post_rst_read");
    chk("post_rst.reg3", DATA_R[31:0], 32'd0);
    step(1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 5'd0, 5'd0, 1'b0, "post_rst_wr");
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd3, 1'b0, "post_rst_rd");
    chk("post_rst.reg7", DATA_R[31:0], 32'hCAFE_F00D);
    chk("post_rst.valid", {31'd0, R_VALID}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom), $urandom_range(0, 79) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
